// File: rtl/matvec_pkg.sv
// Shared types and sizing helpers for the sequential matrix-vector MAC.
package matvec_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } matvec_state_t;

  // Default accumulator width: full product width plus growth for DIM terms.
  function automatic int acc_width(input int dim, input int data_w);
    return 2 * data_w + $clog2(dim);
  endfunction

  // Width of the flat element index that walks DIM*DIM MAC steps.
  function automatic int idx_width(input int dim);
    return $clog2(dim * dim);
  endfunction

  localparam int MATVEC_DIM_DEFAULT = 4;
  localparam int IDX_W = idx_width(MATVEC_DIM_DEFAULT);

endpackage

// File: rtl/matvec_mac_unit.sv
// Combinational multiply-accumulate step: acc_out = acc_in + a*b.
// The product is full precision and sign-extended before the add.
// MATVEC_SATURATE_EN defined: an overflowing add clamps to the signed
// max/min of ACC_W. Undefined: the add wraps modulo 2^ACC_W.
// In both builds ovf flags the out-of-range add.
module matvec_mac_unit
  import matvec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 34
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [ACC_W-1:0]  acc_in,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     ovf
);

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0]  prod_s;
  logic signed [ACC_W:0] sum_s;

  // Full-precision product, then one-bit-wider sum so overflow is visible.
  always_comb begin
    prod_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    sum_s  = $signed({acc_in[ACC_W-1], acc_in})
           + $signed({{(ACC_W+1-PW){prod_s[PW-1]}}, prod_s});
    ovf    = (sum_s[ACC_W] != sum_s[ACC_W-1]);
  end

  // Resolve an out-of-range sum by clamping or by dropping the carry bit.
  always_comb begin
`ifdef MATVEC_SATURATE_EN
    if (ovf) begin
      if (sum_s[ACC_W]) begin
        acc_out = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        acc_out = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      acc_out = sum_s[ACC_W-1:0];
    end
`else
    acc_out = sum_s[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/matrix_vector_mac_seq.sv
// Sequential fixed-point matrix-vector multiplier, one MAC per clock.
// Computes M*v, or M^T*v when i_transpose is set at the accept edge.
// Operands are captured on accept so upstream may change them freely.
// Optional build macro MATVEC_SATURATE_EN selects saturating accumulation
// (see matvec_mac_unit); the default build wraps.
module matrix_vector_mac_seq
  import matvec_pkg::*;
#(
  parameter int DIM    = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = acc_width(DIM, DATA_W)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  output logic                        i_ready,
  input  logic [DIM*DIM*DATA_W-1:0]   i_mat,
  input  logic [DIM*DATA_W-1:0]       i_vec,
  input  logic                        i_transpose,
  output logic [DIM*ACC_W-1:0]        o_product,
  output logic                        o_overflow,
  output logic                        o_valid,
  input  logic                        o_ready
);

  localparam int IW = idx_width(DIM);
  localparam int RW = $clog2(DIM);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIM * DIM - 1);
  localparam logic [IW-1:0] DIM_IDX  = IW'(DIM);

  matvec_state_t            state_r;
  logic [IW-1:0]            idx_r;
  logic signed [DATA_W-1:0] mat_r [DIM*DIM];
  logic signed [DATA_W-1:0] vec_r [DIM];
  logic                     transpose_r;
  logic signed [ACC_W-1:0]  acc_r [DIM];
  logic                     overflow_r;

  logic [RW-1:0]            row_s;
  logic [RW-1:0]            col_s;
  logic [IW-1:0]            sel_s;
  logic signed [DATA_W-1:0] mac_a_s;
  logic signed [DATA_W-1:0] mac_b_s;
  logic signed [ACC_W-1:0]  acc_in_s;
  logic signed [ACC_W-1:0]  acc_out_s;
  logic                     mac_ovf_s;

  // Split the flat index into row/column and pick M[r][c] or M[c][r].
  always_comb begin
    row_s = RW'(idx_r / DIM_IDX);
    col_s = RW'(idx_r % DIM_IDX);
    if (transpose_r) begin
      sel_s = IW'(col_s) * DIM_IDX + IW'(row_s);
    end else begin
      sel_s = idx_r;
    end
    mac_a_s  = mat_r[sel_s];
    mac_b_s  = vec_r[col_s];
    acc_in_s = acc_r[row_s];
  end

  matvec_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .a       (mac_a_s),
    .b       (mac_b_s),
    .acc_in  (acc_in_s),
    .acc_out (acc_out_s),
    .ovf     (mac_ovf_s)
  );

  // Handshake flags are pure state decodes; i_ready is masked during reset.
  always_comb begin
    i_ready    = (state_r == S_IDLE) && !rst;
    o_valid    = (state_r == S_DONE);
    o_overflow = overflow_r;
  end

  genvar gr;
  generate
    for (gr = 0; gr < DIM; gr++) begin : g_out
      assign o_product[gr*ACC_W +: ACC_W] = acc_r[gr];
    end
  endgenerate

  // FSM, operand capture, index walk and accumulator update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      idx_r       <= {IW{1'b0}};
      transpose_r <= 1'b0;
      overflow_r  <= 1'b0;
      for (int k = 0; k < DIM * DIM; k++) begin
        mat_r[k] <= {DATA_W{1'b0}};
      end
      for (int k = 0; k < DIM; k++) begin
        vec_r[k] <= {DATA_W{1'b0}};
        acc_r[k] <= {ACC_W{1'b0}};
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (i_valid && i_ready) begin
            for (int k = 0; k < DIM * DIM; k++) begin
              mat_r[k] <= i_mat[k*DATA_W +: DATA_W];
            end
            for (int k = 0; k < DIM; k++) begin
              vec_r[k] <= i_vec[k*DATA_W +: DATA_W];
              acc_r[k] <= {ACC_W{1'b0}};
            end
            transpose_r <= i_transpose;
            overflow_r  <= 1'b0;
            idx_r       <= {IW{1'b0}};
            state_r     <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          acc_r[row_s] <= acc_out_s;
          overflow_r   <= overflow_r | mac_ovf_s;
          if (idx_r == LAST_IDX) begin
            idx_r   <= {IW{1'b0}};
            state_r <= S_DONE;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        S_DONE: begin
          if (o_ready) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
